pcs_tx_scheduler: RTL and testbench

//  Sequences the 64b/66b TX coder/scrambler input. Each cycle the coder accepts a beat, it receives exactly one

---
 rtl/pcs_tx_pkg.sv | 33 +++
 rtl/pcs_tx_scheduler.sv | 153 +++++++++++++++
 tb/tb_pcs_tx_scheduler.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pcs_tx_pkg.sv
// Shared types, block constants and block builders for the 64b/66b TX scheduler.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pcs_tx_pkg;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        GAP   = 2'd1,
        FRAME = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [1:0] SH_DATA = 2'b01;
    localparam logic [1:0] SH_CTRL = 2'b10;
    localparam logic [7:0] BT_IDLE = 8'h1E;
    localparam logic [7:0] BT_OS   = 8'h4B;
    localparam logic [6:0] C_ERROR = 7'h1E;

    // All-idle control block: eight idle control characters are zero.
    function automatic logic [63:0] idle_blk();
        return {56'h0, BT_IDLE};
    endfunction

    // Control block carrying eight /E/ characters, used to poison an aborted frame.
    function automatic logic [63:0] err_blk();
        return {{8{C_ERROR}}, BT_IDLE};
    endfunction

    function automatic logic [63:0] os_blk(input logic [55:0] os_data);
        return {os_data, BT_OS};
    endfunction

endpackage

// File: rtl/pcs_tx_scheduler.sv
// Picks one 66b block per coder beat: MAC data, an injected ordered set, or local idle/error.
// Latency: 1 cycle from input handshake (data beat or os_ack) to the output register.
// Backpressure: output reloads only when m_axis_tready | ~m_axis_tvalid; all state holds otherwise.
//
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   s_data_t{type,data,last,valid,ready}  MAC block stream (ttype = sync header)
//   os_req / os_data / os_ack   level request for one ordered set, acked when loaded
//   m_axis_t{type,data,valid,ready}       block stream to the coder/scrambler
//   underrun_cnt                saturating count of frames aborted by underrun
//   init_done                   high once the post-reset idle run has finished
module pcs_tx_scheduler
    import pcs_tx_pkg::*;
#(
    parameter int INIT_IDLES = 16,
    parameter int MIN_GAP    = 2,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       s_data_ttype,
    input  logic [63:0]      s_data_tdata,
    input  logic             s_data_tlast,
    input  logic             s_data_tvalid,
    output logic             s_data_tready,
    input  logic             os_req,
    input  logic [55:0]      os_data,
    output logic             os_ack,
    output logic [1:0]       m_axis_ttype,
    output logic [63:0]      m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic [CNT_W-1:0] underrun_cnt,
    output logic             init_done
);

    localparam logic [15:0] INIT_LAST = 16'(INIT_IDLES - 1);
    localparam logic [7:0]  GAP_MIN   = 8'(MIN_GAP);

    state_t      state, nxt_state;
    logic [15:0] init_cnt, nxt_init;
    logic [7:0]  gap_cnt, nxt_gap, gap_inc;
    logic        gap_ok;
    logic        adv;
    logic [1:0]  ld_ttype;
    logic [63:0] ld_tdata;
    logic        ld_uflow;

    // Output register is free when empty or being drained this cycle.
    assign adv     = m_axis_tready | ~m_axis_tvalid;
    assign gap_ok  = (gap_cnt >= GAP_MIN);
    assign gap_inc = (gap_cnt == 8'hFF) ? gap_cnt : gap_cnt + 8'd1;

    // INIT never recurs without reset, so leaving it marks the idle run complete.
    assign init_done = (state != INIT);

    // In GAP a pending ordered set outranks data, so data is refused while os_req is up.
    assign s_data_tready = adv & ((state == FRAME) |
                                  (state == DRAIN) |
                                  ((state == GAP) & gap_ok & ~os_req));

    always_comb begin
        nxt_state = state;
        nxt_init  = init_cnt;
        nxt_gap   = gap_cnt;
        ld_ttype  = SH_CTRL;
        ld_tdata  = idle_blk();
        ld_uflow  = 1'b0;
        os_ack    = 1'b0;
        case (state)
            INIT: begin
                nxt_init = init_cnt + 16'd1;
                if (init_cnt == INIT_LAST) begin
                    nxt_state = GAP;
                end
            end
            GAP: begin
                if (os_req) begin
                    ld_tdata = os_blk(os_data);
                    os_ack   = adv;
                    nxt_gap  = gap_inc;
                end else if (gap_ok && s_data_tvalid) begin
                    ld_ttype = s_data_ttype;
                    ld_tdata = s_data_tdata;
                    if (s_data_tlast) begin
                        // Single-beat frame: the gap restarts right away.
                        nxt_gap = 8'd0;
                    end else begin
                        nxt_state = FRAME;
                    end
                end else begin
                    nxt_gap = gap_inc;
                end
            end
            FRAME: begin
                if (s_data_tvalid) begin
                    ld_ttype = s_data_ttype;
                    ld_tdata = s_data_tdata;
                    if (s_data_tlast) begin
                        nxt_state = GAP;
                        nxt_gap   = 8'd0;
                    end
                end else begin
                    // The scrambler cannot stall, so a late beat kills the frame.
                    ld_tdata  = err_blk();
                    ld_uflow  = 1'b1;
                    nxt_state = DRAIN;
                end
            end
            DRAIN: begin
                // Remaining beats of the aborted frame are swallowed; idles go out.
                if (s_data_tvalid && s_data_tlast) begin
                    nxt_state = GAP;
                    nxt_gap   = 8'd0;
                end
            end
            default: nxt_state = INIT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= INIT;
            init_cnt <= 16'd0;
            gap_cnt  <= GAP_MIN;
        end else if (adv) begin
            state    <= nxt_state;
            init_cnt <= nxt_init;
            gap_cnt  <= nxt_gap;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_axis_tvalid <= 1'b0;
            m_axis_ttype  <= 2'b00;
            m_axis_tdata  <= 64'h0;
        end else if (adv) begin
            m_axis_tvalid <= 1'b1;
            m_axis_ttype  <= ld_ttype;
            m_axis_tdata  <= ld_tdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            underrun_cnt <= '0;
        end else if (adv && ld_uflow && (underrun_cnt != {CNT_W{1'b1}})) begin
            underrun_cnt <= underrun_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pcs_tx_scheduler.sv
// Randomized bench for pcs_tx_scheduler against a behavioural block-sequencing model.
// Latency: model predicts the output register contents one cycle after each accepted choice.
// Backpressure: random m_axis_tready bursts; MAC source may drop valid mid-frame to force underruns.
module tb_pcs_tx_scheduler;

    localparam int INIT_IDLES = 16;
    localparam int MIN_GAP    = 2;
    localparam int CNT_W      = 16;
    localparam int N_CYC      = 4000;

    localparam logic [63:0] EXP_IDLE = 64'h0000_0000_0000_001E;
    localparam logic [63:0] EXP_ERR  = {{8{7'h1E}}, 8'h1E};

    logic             clk;
    logic             reset;
    logic [1:0]       s_data_ttype;
    logic [63:0]      s_data_tdata;
    logic             s_data_tlast;
    logic             s_data_tvalid;
    logic             s_data_tready;
    logic             os_req;
    logic [55:0]      os_data;
    logic             os_ack;
    logic [1:0]       m_axis_ttype;
    logic [63:0]      m_axis_tdata;
    logic             m_axis_tvalid;
    logic             m_axis_tready;
    logic [CNT_W-1:0] underrun_cnt;
    logic             init_done;

    pcs_tx_scheduler #(
        .INIT_IDLES (INIT_IDLES),
        .MIN_GAP    (MIN_GAP),
        .CNT_W      (CNT_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .s_data_ttype  (s_data_ttype),
        .s_data_tdata  (s_data_tdata),
        .s_data_tlast  (s_data_tlast),
        .s_data_tvalid (s_data_tvalid),
        .s_data_tready (s_data_tready),
        .os_req        (os_req),
        .os_data       (os_data),
        .os_ack        (os_ack),
        .m_axis_ttype  (m_axis_ttype),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .underrun_cnt  (underrun_cnt),
        .init_done     (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The link is described as: idles still owed after reset, whether a frame is on
    // the wire, whether it was aborted, and how many non-data blocks since the last end.
    bit          m_vld;
    logic [1:0]  m_type;
    logic [63:0] m_dat;
    int          m_idles;
    bit          m_in_frame;
    bit          m_aborted;
    int          m_since_end;
    int          m_uf;
    int          n_uf_seen;
    int          n_os_seen;

    task automatic model_reset();
        m_vld       = 1'b0;
        m_type      = 2'b00;
        m_dat       = 64'h0;
        m_idles     = 0;
        m_in_frame  = 1'b0;
        m_aborted   = 1'b0;
        m_since_end = MIN_GAP;
        m_uf        = 0;
    endtask

    function automatic bit model_adv();
        return m_axis_tready || !m_vld;
    endfunction

    function automatic bit model_tready();
        if (!model_adv() || m_idles < INIT_IDLES) return 1'b0;
        return m_in_frame || m_aborted || (m_since_end >= MIN_GAP && !os_req);
    endfunction

    function automatic bit model_ack();
        return model_adv() && m_idles >= INIT_IDLES && !m_in_frame && !m_aborted && os_req;
    endfunction

    task automatic send_idle();
        m_type = 2'b10;
        m_dat  = EXP_IDLE;
    endtask

    task automatic model_step();
        if (!model_adv()) return;
        m_vld = 1'b1;
        if (m_idles < INIT_IDLES) begin
            send_idle();
            m_idles++;
        end else if (m_aborted) begin
            send_idle();
            if (s_data_tvalid && s_data_tlast) begin
                m_aborted   = 1'b0;
                m_since_end = 0;
            end
        end else if (m_in_frame) begin
            if (s_data_tvalid) begin
                m_type = s_data_ttype;
                m_dat  = s_data_tdata;
                if (s_data_tlast) begin
                    m_in_frame  = 1'b0;
                    m_since_end = 0;
                end
            end else begin
                m_type    = 2'b10;
                m_dat     = EXP_ERR;
                m_aborted = 1'b1;
                m_in_frame = 1'b0;
                if (m_uf < 65535) m_uf++;
                n_uf_seen++;
            end
        end else if (os_req) begin
            m_type = 2'b10;
            m_dat  = {os_data, 8'h4B};
            if (m_since_end < 255) m_since_end++;
            n_os_seen++;
        end else if (m_since_end >= MIN_GAP && s_data_tvalid) begin
            m_type = s_data_ttype;
            m_dat  = s_data_tdata;
            if (s_data_tlast) m_since_end = 0;
            else              m_in_frame = 1'b1;
        end else begin
            send_idle();
            if (m_since_end < 255) m_since_end++;
        end
    endtask

    // ---------------- stimulus ----------------
    logic [1:0]  f_type[$];
    logic [63:0] f_dat[$];
    bit          src_started;
    int          rdy_low_left;

    task automatic src_clear();
        f_type.delete();
        f_dat.delete();
        src_started   = 1'b0;
        s_data_tvalid = 1'b0;
        s_data_tlast  = 1'b0;
        os_req        = 1'b0;
    endtask

    task automatic drive_inputs(input bit fired, input bit acked);
        logic [63:0] rnd;
        logic [1:0]  tt;
        int          len;
        if (fired && f_dat.size() > 0) begin
            void'(f_dat.pop_front());
            void'(f_type.pop_front());
            src_started = (f_dat.size() > 0);
        end
        if (f_dat.size() == 0 && $urandom_range(0, 2) == 0) begin
            len = $urandom_range(1, 5);
            for (int i = 0; i < len; i++) begin
                rnd = {$urandom, $urandom};
                // Mostly data sync headers, occasionally control or illegal ones.
                case ($urandom_range(0, 7))
                    0:       tt = 2'b10;
                    1:       tt = 2'b00;
                    2:       tt = 2'b11;
                    default: tt = 2'b01;
                endcase
                f_dat.push_back(rnd);
                f_type.push_back(tt);
            end
        end
        if (f_dat.size() > 0) begin
            s_data_tdata  = f_dat[0];
            s_data_ttype  = f_type[0];
            s_data_tlast  = (f_dat.size() == 1);
            s_data_tvalid = !src_started || ($urandom_range(0, 11) != 0);
        end else begin
            s_data_tvalid = 1'b0;
            s_data_tlast  = 1'b0;
        end
        if (acked) begin
            os_req = 1'b0;
        end else if (!os_req && $urandom_range(0, 19) == 0) begin
            rnd     = {$urandom, $urandom};
            os_req  = 1'b1;
            os_data = rnd[55:0];
        end
        if (rdy_low_left > 0) begin
            rdy_low_left--;
            m_axis_tready = 1'b0;
        end else if ($urandom_range(0, 24) == 0) begin
            rdy_low_left  = $urandom_range(1, 5);
            m_axis_tready = 1'b0;
        end else begin
            m_axis_tready = 1'b1;
        end
    endtask

    task automatic check_reset_state(input string pfx);
        chk({pfx, "_tvalid"}, 64'(m_axis_tvalid), 64'd0);
        chk({pfx, "_tdata"},  m_axis_tdata,       64'd0);
        chk({pfx, "_ttype"},  64'(m_axis_ttype),  64'd0);
        chk({pfx, "_s_rdy"},  64'(s_data_tready), 64'd0);
        chk({pfx, "_os_ack"}, 64'(os_ack),        64'd0);
        chk({pfx, "_uflow"},  64'(underrun_cnt),  64'd0);
        chk({pfx, "_init"},   64'(init_done),     64'd0);
    endtask

    task automatic check_cycle();
        chk("tvalid",   64'(m_axis_tvalid), 64'(m_vld));
        chk("ttype",    64'(m_axis_ttype),  64'(m_type));
        chk("tdata",    m_axis_tdata,       m_dat);
        chk("s_tready", 64'(s_data_tready), 64'(model_tready()));
        chk("os_ack",   64'(os_ack),        64'(model_ack()));
        chk("uflow",    64'(underrun_cnt),  64'(m_uf));
        chk("init",     64'(init_done),     64'(m_idles >= INIT_IDLES));
    endtask

    initial begin
        bit fired;
        bit acked;
        bit did_rst;
        reset         = 1'b1;
        s_data_ttype  = 2'b00;
        s_data_tdata  = 64'h0;
        os_data       = 56'h0;
        m_axis_tready = 1'b1;
        rdy_low_left  = 0;
        n_uf_seen     = 0;
        n_os_seen     = 0;
        src_clear();
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_reset_state("rst");
        @(negedge clk);
        reset   = 1'b0;
        fired   = 1'b0;
        acked   = 1'b0;
        did_rst = 1'b0;

        for (int cyc = 0; cyc < N_CYC; cyc++) begin
            if (!did_rst && cyc >= N_CYC / 2 && m_in_frame) begin
                // Drop reset on a live frame: the frame is lost, no error block appears.
                did_rst = 1'b1;
                reset   = 1'b1;
                src_clear();
                model_reset();
                #1;
                check_reset_state("midrst");
                @(negedge clk);
                reset = 1'b0;
                fired = 1'b0;
                acked = 1'b0;
            end
            drive_inputs(fired, acked);
            #1;
            check_cycle();
            fired = s_data_tvalid && s_data_tready;
            acked = os_ack;
            @(posedge clk);
            model_step();
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
